// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction-fetch stage.
// Owns the PC and addresses a combinational imem ROM. The returned word is
// captured into the IF/ID register. Handles stalls, branch redirects, decode
// flushes and the end-of-program HALT self-loop.
// Optional feature: define FETCH_PERF_EN to add fetch_count_o, a saturating
// count of instructions loaded into IF/ID.
module fetch_stage #(
    parameter int          N         = 64,
    parameter int          IMEM_AW   = 6,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [31:0] HALT_INSN = 32'hb400001f
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_q,
    input  logic               stall_F,
    input  logic               flush_D,
    input  logic               PCSrc_F,
    input  logic [N-1:0]       PCBranch_F,
    output logic [31:0]        instr_D,
    output logic [N-1:0]       pc_D,
    output logic               valid_D,
    output logic               halted_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count_o
`endif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_pc;
    logic [N-1:0]   w_pc_nxt;
    logic [31:0]    r_instr_D;
    logic [N-1:0]   r_pc_D;
    logic           r_valid_D;
    logic           r_halted;
    logic           w_halted_nxt;
    logic           w_load;
    logic           w_bubble;

    // Word address into the ROM; upper PC bits wrap out of the 64-entry space.
    assign imem_addr = r_pc[IMEM_AW+1:2];
    assign instr_D   = r_instr_D;
    assign pc_D      = r_pc_D;
    assign valid_D   = r_valid_D;
    assign halted_o  = r_halted;

    // State register: FSM state, PC and the registered halt flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_BOOT;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Next-state, next-PC and IF/ID load/bubble decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_halted_nxt = 1'b0;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        case (r_state)
            S_BOOT: begin
                // One idle cycle after reset; redirects are ignored here.
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (PCSrc_F) begin
                    w_pc_nxt = PCBranch_F;
                    w_bubble = 1'b1;
                end else if (!stall_F) begin
                    w_pc_nxt = r_pc + N'(4);
                    if (!flush_D) begin
                        w_load = 1'b1;
                        if (imem_q == HALT_INSN) begin
                            w_state_nxt = S_HALT;
                        end
                    end
                end
            end
            S_HALT: begin
                if (PCSrc_F) begin
                    // Wrong-path halt or the halt's own self-branch: resume.
                    w_pc_nxt    = PCBranch_F;
                    w_bubble    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_halted_nxt = 1'b1;
                    if (!stall_F) begin
                        w_bubble = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
        // A decode flush clears IF/ID even when stalled; PC is unaffected.
        if (flush_D) begin
            w_load   = 1'b0;
            w_bubble = 1'b1;
        end
    end

    // IF/ID pipeline register: load, clear to bubble, or hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_D <= 32'd0;
            r_pc_D    <= '0;
            r_valid_D <= 1'b0;
        end else if (w_load) begin
            r_instr_D <= imem_q;
            r_pc_D    <= r_pc;
            r_valid_D <= 1'b1;
        end else if (w_bubble) begin
            r_instr_D <= 32'd0;
            r_pc_D    <= '0;
            r_valid_D <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;

    // Saturating count of real instructions entering IF/ID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_count <= 32'd0;
        end else if (w_load && (r_fetch_count != 32'hffffffff)) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count_o = r_fetch_count;
`else
    // No fetch performance counter in this build.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a combinational ROM model.
module tb_fetch_stage;

    localparam int N       = 64;
    localparam int IMEM_AW = 6;
    localparam logic [31:0] HALT = 32'hb400001f;

    logic               clk;
    logic               reset;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_q;
    logic               stall_F;
    logic               flush_D;
    logic               PCSrc_F;
    logic [N-1:0]       PCBranch_F;
    logic [31:0]        instr_D;
    logic [N-1:0]       pc_D;
    logic               valid_D;
    logic               halted_o;
`ifdef FETCH_PERF_EN
    logic [31:0]        fetch_count_o;
`endif

    logic [31:0] rom [0:63];
    int n_tests;
    int n_fail;

    fetch_stage #(.N(N), .IMEM_AW(IMEM_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_q     (imem_q),
        .stall_F    (stall_F),
        .flush_D    (flush_D),
        .PCSrc_F    (PCSrc_F),
        .PCBranch_F (PCBranch_F),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .valid_D    (valid_D),
        .halted_o   (halted_o)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count_o (fetch_count_o)
`endif
    );

    assign imem_q = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 64; i++) rom[i] = 32'h8b000000 | i;
        rom[0]  = 32'hf8000001;
        rom[1]  = 32'hf8008002;
        rom[2]  = 32'hf8000203;
        rom[46] = HALT;

        reset      = 1'b0;
        stall_F    = 1'b0;
        flush_D    = 1'b0;
        PCSrc_F    = 1'b0;
        PCBranch_F = '0;

        #3;
        check("rst_valid", valid_D, 0);
        check("rst_instr", instr_D, 0);
        check("rst_pcD", pc_D, 0);
        check("rst_halt", halted_o, 0);
        check("rst_addr", imem_addr, 0);

        #9 reset = 1'b1;

        // BOOT cycle
        step();
        check("boot_valid", valid_D, 0);
        check("boot_addr", imem_addr, 0);

        step();
        check("f0_instr", instr_D, 32'hf8000001);
        check("f0_pcD", pc_D, 0);
        check("f0_valid", valid_D, 1);
        step();
        check("f1_instr", instr_D, 32'hf8008002);
        check("f1_pcD", pc_D, 4);
        check("f1_addr", imem_addr, 2);

        // Stall two cycles
        stall_F = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stl_instr", instr_D, 32'hf8008002);
            check("stl_pcD", pc_D, 4);
            check("stl_valid", valid_D, 1);
            check("stl_addr", imem_addr, 2);
        end
        stall_F = 1'b0;
        step();
        check("f2_instr", instr_D, 32'hf8000203);
        check("f2_pcD", pc_D, 8);
        check("f2_addr", imem_addr, 3);
`ifdef FETCH_PERF_EN
        check("cnt3", fetch_count_o, 3);
`endif

        // Redirect has priority over stall
        PCSrc_F    = 1'b1;
        stall_F    = 1'b1;
        PCBranch_F = 64'h40;
        step();
        check("br_valid", valid_D, 0);
        check("br_instr", instr_D, 0);
        check("br_addr", imem_addr, 16);
        PCSrc_F = 1'b0;
        stall_F = 1'b0;
        step();
        check("br_pcD", pc_D, 64'h40);
        check("br_valid1", valid_D, 1);
        check("br_instr1", instr_D, 32'h8b000010);

        // Flush overrides stall for IF/ID; pc holds
        flush_D = 1'b1;
        stall_F = 1'b1;
        step();
        check("fl_instr", instr_D, 0);
        check("fl_valid", valid_D, 0);
        check("fl_addr", imem_addr, 17);
        flush_D = 1'b0;
        stall_F = 1'b0;
        step();
        check("fl_pcD", pc_D, 64'h44);

        // Run sequentially to the halt word at 46
        repeat (29) step();
        check("h_instr", instr_D, HALT);
        check("h_pcD", pc_D, 184);
        check("h_halt0", halted_o, 0);
        check("h_addr", imem_addr, 47);
        step();
        check("h_halt1", halted_o, 1);
        check("h_bub", valid_D, 0);
        check("h_addr1", imem_addr, 47);
        step();
        check("h_halt2", halted_o, 1);
        check("h_addr2", imem_addr, 47);

        // Self-branch refetches the halt
        PCSrc_F    = 1'b1;
        PCBranch_F = 64'd184;
        step();
        check("rf_halt", halted_o, 0);
        check("rf_addr", imem_addr, 46);
        check("rf_valid", valid_D, 0);
        PCSrc_F = 1'b0;
        step();
        check("rf_instr", instr_D, HALT);
        check("rf_pcD", pc_D, 184);
        step();
        check("rf_halt1", halted_o, 1);
`ifdef FETCH_PERF_EN
        check("cnt_end", fetch_count_o, 35);
`endif

        // Async reset between edges
        #2 reset = 1'b0;
        #1;
        check("ar_halt", halted_o, 0);
        check("ar_valid", valid_D, 0);
        check("ar_instr", instr_D, 0);
        check("ar_addr", imem_addr, 0);
`ifdef FETCH_PERF_EN
        check("ar_cnt", fetch_count_o, 0);
`endif
        #10 reset = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 pipeline, directly upstream of the instruction memory.
- Owns the PC register and drives the word address into the imem ROM.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles stalls, branch redirects and decode flushes, and idles fetch on the end-of-program self-loop.

Parameters:
- N, 64, PC/datapath width in bits.
- IMEM_AW, 6, imem word-address width (64-entry ROM).
- RESET_PC, 0, PC value loaded on reset.
- HALT_INSN, 32'hb400001f, encoding that puts fetch into HALT (CBZ XZR, #0 self-loop).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_addr  out  IMEM_AW  word address to imem, combinational = pc[IMEM_AW+1:2].
- imem_q  in  32  instruction returned by imem, same cycle (combinational ROM).
- stall_F  in  1  hazard unit: hold PC and IF/ID.
- flush_D  in  1  hazard unit: clear IF/ID to bubble.
- PCSrc_F  in  1  taken branch/redirect from the later stage.
- PCBranch_F  in  N  redirect target.
- instr_D  out  32  IF/ID instruction.
- pc_D  out  N  IF/ID PC of instr_D.
- valid_D  out  1  IF/ID holds a real instruction.
- halted_o  out  1  fetch is in HALT.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC; instr_D=0; pc_D=0; valid_D=0; halted_o=0; state=BOOT.
- States:
  - BOOT: exactly one cycle after reset release; nothing fetched, IF/ID stays bubble, pc held; then goes to RUN.
  - RUN:
    - PCSrc_F=1: pc<=PCBranch_F; IF/ID<=bubble (instr_D=0, valid_D=0, pc_D=0). Redirect has priority over stall_F.
    - Else stall_F=1: pc and IF/ID hold.
    - Else: pc<=pc+4; instr_D<=imem_q; pc_D<=pc; valid_D<=1.
    - If the loaded imem_q==HALT_INSN, state<=HALT in the same edge.
  - HALT: halted_o=1 (registered, asserted the cycle after the halting instruction enters IF/ID).
    - pc frozen at halt_pc+4.
    - IF/ID releases the halting instruction normally (holds while stall_F); the next non-stalled edge loads a bubble.
    - PCSrc_F=1 in HALT: pc<=PCBranch_F, IF/ID<=bubble, state<=RUN, halted_o<=0. Wrong-path halts are recoverable; the halt's own self-branch refetches it and re-enters HALT.
- flush_D=1: IF/ID<=bubble on that edge, overriding stall_F for IF/ID only; pc follows the RUN rules unchanged.
- PCSrc_F in BOOT is ignored.
- Arithmetic:
  - pc+4 wraps modulo 2^N.
  - imem_addr wraps modulo 2^IMEM_AW words: pc=252 gives addr 63; pc=256 gives addr 0.
  - PCBranch_F bits [1:0] are ignored for addressing but stored in pc as given.
- Latency: one cycle from imem_addr to the instruction appearing in instr_D.
- Reset mid-operation clears everything immediately, independent of clk.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds output fetch_count_o [31:0].
  - Increments on each edge where IF/ID loads with valid_D<=1.
  - Saturates at 32'hffffffff.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release with imem ROM at words 0..2 = 32'hf8000001, 32'hf8008002, 32'hf8000203 -> BOOT cycle valid_D=0; then instr_D = the three words on consecutive cycles with pc_D=0,4,8 and valid_D=1.
- stall_F=1 for 2 cycles while instr_D=32'hf8008002 (pc_D=4) -> instr_D/pc_D/valid_D and imem_addr hold; fetch resumes at pc=8.
- PCSrc_F=1, stall_F=1, PCBranch_F=0x40 together -> next cycle valid_D=0, imem_addr=16; following cycle pc_D=0x40, valid_D=1.
- flush_D=1 with stall_F=1 -> instr_D=0, valid_D=0, pc unchanged.
- ROM word 46 = 32'hb400001f reached -> instr_D=32'hb400001f, pc_D=184; halted_o=1 next cycle; pc stays 188; bubbles follow. Then PCSrc_F=1 with target 184 -> halted_o=0, refetch, HALT again.
- Async reset pulse mid-stream (between edges) -> outputs clear immediately. With FETCH_PERF_EN after scenario 1: fetch_count_o=3.
